// File: rtl/nrisc_pkg.sv
// nrisc shared definitions.
// State and next-PC select encodings.
package nrisc_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    VALID = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JMP  = 2'b10,
    PC_HALT = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/ExtensorSinal2pra8.sv
// nrisc 2-to-8 sign extender.
// Replicates bit 1 into the upper six bits.
module ExtensorSinal2pra8 (
  input  logic [1:0] entrada,
  output logic [7:0] saida
);

  assign saida = {{6{entrada[1]}}, entrada};

endmodule

// File: rtl/somador.sv
// nrisc adder.
// Plain modulo-2^W sum.
module somador #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] soma
);

  assign soma = a + b;

endmodule

// File: rtl/unidade_busca.sv
// nrisc instruction-fetch unit.
// Owns the PC, fetches, holds instr for decode.
module unidade_busca
  import nrisc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [1:0]        pc_sel,
  input  logic [1:0]        br_off,
  input  logic [WORD_W-1:0] jmp_target,
  output logic              halted
);

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_nx;
  logic [WORD_W-1:0] pc_inc;
  logic [WORD_W-1:0] off_ext;
  logic [WORD_W-1:0] br_tgt;

  somador #(.W(WORD_W)) u_inc (
    .a    (pc),
    .b    (8'd1),
    .soma (pc_inc)
  );

  ExtensorSinal2pra8 u_ext (
    .entrada (br_off),
    .saida   (off_ext)
  );

  assign br_tgt = instr_pc + off_ext;

  // Next state and next PC; PC only moves on the decode handshake
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    unique case (state)
      BOOT:  state_nx = FETCH;
      FETCH: if (imem_ack) state_nx = VALID;
      VALID: begin
        if (instr_ready) begin
          state_nx = FETCH;
          unique case (pc_sel_t'(pc_sel))
            PC_SEQ:  pc_nx = pc_inc;
            PC_BR:   pc_nx = br_tgt;
            PC_JMP:  pc_nx = jmp_target;
            PC_HALT: state_nx = HALT;
          endcase
        end
      end
      HALT:  state_nx = HALT;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // Capture the returned word and its address on ack in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (state == FETCH && imem_ack) begin
      instr    <= imem_data;
      instr_pc <= pc;
    end
  end

  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca.
// Scoreboard of expected fetch addresses.
module tb_unidade_busca;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] pc_sel;
  logic [1:0] br_off;
  logic [7:0] jmp_target;
  logic       halted;

  logic       auto_ack;
  logic       ack_force;
  logic [7:0] data_xor;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic [7:0] m_pc;

  always #5 clk = ~clk;

  assign imem_ack  = ack_force | (auto_ack & imem_req);
  assign imem_data = imem_addr ^ data_xor;

  unidade_busca #(.RESET_PC(8'h10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_sel      (pc_sel),
    .br_off      (br_off),
    .jmp_target  (jmp_target),
    .halted      (halted)
  );

  // Handshake in VALID; push the expected next fetch address
  task automatic hs(input logic [1:0] sel,
                    input logic [1:0] off,
                    input logic [7:0] tgt);
    logic [7:0] nxt;
    logic [7:0] ofs;
    case (off)
      2'b00: ofs = 8'h00;
      2'b01: ofs = 8'h01;
      2'b10: ofs = 8'hFE;
      default: ofs = 8'hFF;
    endcase
    case (sel)
      2'b00: nxt = m_pc + 8'h01;
      2'b01: nxt = m_pc + ofs;
      default: nxt = tgt;
    endcase
    if (sel != 2'b11) exp_q.push_back(nxt);
    instr_ready = 1'b1;
    pc_sel      = sel;
    br_off      = off;
    jmp_target  = tgt;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    pc_sel      = 2'($urandom);
    br_off      = 2'($urandom);
    jmp_target  = 8'($urandom);
    @(negedge clk);
  endtask

  // Serve one fetch, acking after 'delay' extra cycles
  task automatic fetch(input int delay,
                       output logic [7:0] addr,
                       output int nreq,
                       output bit stable,
                       output bit ok);
    addr   = imem_addr;
    nreq   = 0;
    stable = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!imem_req) begin
        ok = (nreq > 0);
        break;
      end
      if (imem_addr !== addr) stable = 1'b0;
      nreq++;
      if (nreq == delay + 1) ack_force = 1'b1;
      @(posedge clk);
      #1;
      ack_force = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n       = 1'b0;
    auto_ack    = 1'b1;
    ack_force   = 1'b0;
    data_xor    = 8'h5A;
    instr_ready = 1'b0;
    pc_sel      = 2'b00;
    br_off      = 2'b00;
    jmp_target  = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b want 0", imem_req);
    end
    checks++;
    if (imem_addr !== 8'h10) begin
      errors++; $display("FAIL rst_addr got %h want 10", imem_addr);
    end
    checks++;
    if (instr !== 8'h00 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL rst_instr got %h/%h want 00/00", instr, instr_pc);
    end
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got v%b h%b want 0 0", instr_valid, halted);
    end
    exp_q.push_back(8'h10);
    rst_n = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== e || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_fetch got r%b a%h v%b want r1 a%h v0",
               imem_req, imem_addr, instr_valid, e);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e || instr !== (e ^ 8'h5A)) begin
      errors++;
      $display("FAIL boot_valid got v%b pc%h i%h want v1 pc%h i%h",
               instr_valid, instr_pc, instr, e, e ^ 8'h5A);
    end
    m_pc     = e;
    auto_ack = 1'b0;
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    logic [7:0] e;
    int         n;
    bit         s;
    bit         ok;
    hs(2'b10, 2'b00, 8'hFE);
    for (int k = 0; k < 3; k++) begin
      fetch(0, a, n, s, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || a !== e) begin
        errors++; $display("FAIL seq_addr%0d got %h want %h", k, a, e);
      end
      checks++;
      if (instr_pc !== e || instr !== (e ^ 8'h5A)) begin
        errors++;
        $display("FAIL seq_instr%0d got %h/%h want %h/%h",
                 k, instr_pc, instr, e, e ^ 8'h5A);
      end
      m_pc = e;
      if (k < 2) hs(2'b00, 2'b00, 8'h00);
    end
  endtask

  task automatic test_branch();
    logic [1:0] sel_t[5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    logic [1:0] off_t[5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    logic [7:0] tgt_t[5] = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] a;
    logic [7:0] e;
    int         n;
    bit         s;
    bit         ok;
    for (int k = 0; k < 5; k++) begin
      hs(sel_t[k], off_t[k], tgt_t[k]);
      fetch(0, a, n, s, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || a !== e || instr_pc !== e) begin
        errors++;
        $display("FAIL br_addr%0d got %h/%h want %h", k, a, instr_pc, e);
      end
      m_pc = e;
    end
  endtask

  task automatic test_back_to_back();
    int         cnt;
    logic [7:0] e;
    cnt         = 0;
    e           = m_pc + 8'd4;
    auto_ack    = 1'b1;
    instr_ready = 1'b1;
    pc_sel      = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    instr_ready = 1'b0;
    auto_ack    = 1'b0;
    checks++;
    if (cnt != 4) begin
      errors++; $display("FAIL b2b_rate got %0d want 4", cnt);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e) begin
      errors++;
      $display("FAIL b2b_pc got v%b %h want v1 %h", instr_valid, instr_pc, e);
    end
    m_pc = e;
  endtask

  task automatic test_jump_delay();
    logic [7:0] a;
    logic [7:0] e;
    int         n;
    bit         s;
    bit         ok;
    hs(2'b10, 2'b00, 8'hA5);
    fetch(3, a, n, s, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || n != 4 || !s) begin
      errors++;
      $display("FAIL jmp_hold got n%0d stable%b want n4 stable1", n, s);
    end
    checks++;
    if (a !== e || instr_pc !== e) begin
      errors++; $display("FAIL jmp_addr got %h/%h want %h", a, instr_pc, e);
    end
    m_pc      = e;
    data_xor  = 8'hFF;
    ack_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ack_force = 1'b0;
    @(negedge clk);
    data_xor = 8'h5A;
    checks++;
    if (instr !== (e ^ 8'h5A) || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL spur_ack got i%h v%b r%b want i%h v1 r0",
               instr, instr_valid, imem_req, e ^ 8'h5A);
    end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    hs(2'b11, 2'b00, 8'h00);
    checks++;
    if (halted !== 1'b1 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL halt_enter got h%b a%h want h1 a%h", halted, imem_addr, m_pc);
    end
    for (int k = 0; k < 10; k++) begin
      ack_force   = k[0];
      instr_ready = 1'b1;
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    ack_force   = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_hold got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    logic [7:0] e;
    int         n;
    bit         s;
    bit         ok;
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL rst_halt got h%b a%h want h0 a10", halted, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL mid_fetch got r%b want r1", imem_req);
    end
    ack_force = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        instr !== 8'h00 || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL mid_rst got v%b r%b i%h a%h want v0 r0 i00 a10",
               instr_valid, imem_req, instr, imem_addr);
    end
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h10);
    @(negedge clk);
    fetch(1, a, n, s, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e || instr_pc !== e || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got a%h pc%h v%b want %h", a, instr_pc, instr_valid, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_back_to_back();
    test_jump_delay();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
